data_mem_responder: RTL and testbench

Memory-side responder for the core's data load/store port. It accepts one request at a time over a valid/ready handshake and holds it for a programmable number of wait cycles. It then commits stores with byte-lane granularity, or returns sign- or zero-extended load data, over a valid/ready response channel. It replaces the zero-latency combinational data memory when the datapath is moved to a handshaked memory interface.

---
 rtl/data_mem_responder.sv | 190 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: one request at a time, programmable wait, byte-lane stores
// and extended loads. Define DMEM_MISALIGN_TRAP_EN to reject misaligned accesses instead of aligning down.
module data_mem_responder #(
  parameter int unsigned DEPTH_DW = 512,
  parameter int unsigned LATENCY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int unsigned AW     = (DEPTH_DW > 1) ? $clog2(DEPTH_DW) : 1;
  localparam logic [3:0]  LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_write;
  logic [63:0] r_addr;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [63:0] r_wdata;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [63:0] r_rdata;
  logic        r_error;
  logic [63:0] r_mem [DEPTH_DW];

  logic        w_c_write;
  logic [63:0] w_c_addr;
  logic [1:0]  w_c_size;
  logic        w_c_unsigned;
  logic [63:0] w_c_wdata;
  logic [2:0]  w_mask3;
  logic [3:0]  w_nbytes;
  logic [2:0]  w_off;
  logic        w_misal;
  logic        w_range_err;
  logic        w_err;
  logic [AW-1:0] w_idx;
  logic [63:0] w_word;
  logic [63:0] w_shift;
  logic [63:0] w_ld;
  logic [7:0]  w_be;
  logic [63:0] w_wdata_sh;
  logic        w_commit;
  logic        w_we;

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_error = r_error;

  // With zero latency the commit uses the request being accepted on the same edge
  always_comb begin
    w_c_write    = r_write;
    w_c_addr     = r_addr;
    w_c_size     = r_size;
    w_c_unsigned = r_unsigned;
    w_c_wdata    = r_wdata;
    if (r_state == IDLE) begin
      w_c_write    = req_write;
      w_c_addr     = req_addr;
      w_c_size     = req_size;
      w_c_unsigned = req_unsigned;
      w_c_wdata    = req_wdata;
    end
  end

  // Access decode: alignment, range and lane selection
  always_comb begin
    w_mask3 = 3'b000;
    unique case (w_c_size)
      2'd0: w_mask3 = 3'b000;
      2'd1: w_mask3 = 3'b001;
      2'd2: w_mask3 = 3'b011;
      2'd3: w_mask3 = 3'b111;
      default: w_mask3 = 3'b000;
    endcase
    w_nbytes    = 4'd1 << w_c_size;
    w_misal     = |(w_c_addr[2:0] & w_mask3);
    w_off       = w_c_addr[2:0] & ~w_mask3;
    w_range_err = (w_c_addr[63:3] >= 61'(DEPTH_DW));
`ifdef DMEM_MISALIGN_TRAP_EN
    w_err       = w_range_err | w_misal;
`else
    w_err       = w_range_err;
`endif
    w_idx       = w_c_addr[AW+2:3];
    w_word      = r_mem[w_idx];
    w_shift     = w_word >> {w_off, 3'b000};
    w_wdata_sh  = w_c_wdata << {w_off, 3'b000};
    for (int k = 0; k < 8; k++) begin
      w_be[k] = (4'(k) >= {1'b0, w_off}) && (4'(k) < ({1'b0, w_off} + w_nbytes));
    end
  end

  // Load extraction and sign/zero extension
  always_comb begin
    w_ld = w_shift;
    unique case (w_c_size)
      2'd0: w_ld = w_c_unsigned ? {56'd0, w_shift[7:0]}  : {{56{w_shift[7]}},  w_shift[7:0]};
      2'd1: w_ld = w_c_unsigned ? {48'd0, w_shift[15:0]} : {{48{w_shift[15]}}, w_shift[15:0]};
      2'd2: w_ld = w_c_unsigned ? {32'd0, w_shift[31:0]} : {{32{w_shift[31]}}, w_shift[31:0]};
      2'd3: w_ld = w_shift;
      default: w_ld = w_shift;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd0) w_state_nxt = RESP;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      RESP: begin
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_commit = (w_state_nxt == RESP) && (r_state != RESP);
  assign w_we     = w_commit && w_c_write && !w_err && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_addr      <= 64'd0;
      r_size      <= 2'd0;
      r_unsigned  <= 1'b0;
      r_wdata     <= 64'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 64'd0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= (w_state_nxt == IDLE);
      r_rsp_valid <= (w_state_nxt == RESP);
      if (r_state == IDLE && req_valid) begin
        r_write    <= req_write;
        r_addr     <= req_addr;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_wdata    <= req_wdata;
      end
      if (w_commit) begin
        r_error <= w_err;
        r_rdata <= (w_err || w_c_write) ? 64'd0 : w_ld;
      end
    end
  end

  // Array is not reset; only lanes selected by the committed store change
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int k = 0; k < 8; k++) begin
        if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wdata_sh[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed vector table, corner sequences,
// and randomized traffic against a byte-array reference model.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned LAT   = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [63:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_write, z_req_unsigned;
  logic [63:0] z_req_addr, z_req_wdata;
  logic [1:0]  z_req_size;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_error;
  logic [63:0] z_rsp_rdata;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] mm [0:DEPTH*8-1];

  data_mem_responder #(.DEPTH_DW(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  data_mem_responder #(.DEPTH_DW(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_size(z_req_size), .req_unsigned(z_req_unsigned),
    .req_wdata(z_req_wdata), .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_error(z_rsp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: byte array, little-endian, extension by bit replication
  function automatic void model(input bit wr, input logic [63:0] a, input logic [1:0] sz,
                                input bit u, input logic [63:0] wd,
                                output logic [63:0] rd, output bit err);
    int n;
    logic [63:0] base;
    n   = 1 << sz;
    rd  = 64'd0;
    err = 1'b0;
    if (a / 64'd8 >= 64'(DEPTH)) err = 1'b1;
    if (TRAP && (a % 64'(n) != 64'd0)) err = 1'b1;
    base = a - (a % 64'(n));
    if (err) return;
    for (int k = 0; k < n; k++) begin
      if (wr) mm[int'(base[15:0]) + k] = wd[8*k +: 8];
      else    rd[8*k +: 8] = mm[int'(base[15:0]) + k];
    end
    if (!wr && !u && n < 8 && rd[8*n-1] == 1'b1)
      for (int b = 8*n; b < 64; b++) rd[b] = 1'b1;
  endfunction

  task automatic xact(input bit wr, input logic [63:0] a, input logic [1:0] sz, input bit u,
                      input logic [63:0] wd, input int bp,
                      output logic [63:0] rd, output logic er,
                      output logic [63:0] mrd, output bit merr);
    int cyc;
    cyc = 0;
    while (!req_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_size = sz;
    req_unsigned = u; req_wdata = wd;
    @(posedge clk); #1;
    model(wr, a, sz, u, wd, mrd, merr);
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = {$urandom, $urandom};
    req_size = 2'($urandom); req_wdata = {$urandom, $urandom};
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    chk("latency", 64'(cyc), 64'(LAT));
    rd = rsp_rdata;
    er = rsp_error;
    for (int i = 0; i < bp; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h40; req_size = 2'd3;
      req_wdata = {$urandom, $urandom};
      @(posedge clk); #1;
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_rdata_stable", rsp_rdata, rd);
      chk("bp_error_stable", 64'(rsp_error), 64'(er));
      chk("bp_req_ready", 64'(req_ready), 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post_hs_req_ready", 64'(req_ready), 64'd1);
  endtask

  typedef struct {
    bit          wr;
    logic [63:0] a;
    logic [1:0]  sz;
    bit          u;
    logic [63:0] wd;
    int          bp;
    logic [63:0] exp_rd;
    bit          exp_err;
  } vec_t;

  typedef struct {
    bit          wr;
    logic [63:0] a;
    logic [1:0]  sz;
    bit          u;
    logic [63:0] wd;
    logic [63:0] exp_rd;
  } zvec_t;

  initial begin
    vec_t        tv[$];
    zvec_t       zv[$];
    logic [63:0] rd, mrd, a;
    logic        er;
    bit          merr;
    int          r;

    reset = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 64'd0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 64'd0; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = 64'd0; z_req_size = 2'd0;
    z_req_unsigned = 1'b0; z_req_wdata = 64'd0; z_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rdata", rsp_rdata, 64'd0);
    chk("rst_error", 64'(rsp_error), 64'd0);

    // Known contents for the low region and the last doubleword
    for (int i = 0; i < 33; i++) begin
      a = (i == 32) ? 64'hFF8 : 64'(i * 8);
      xact(1'b1, a, 2'd3, 1'b0, {$urandom, $urandom}, 0, rd, er, mrd, merr);
      chk("fill_err", 64'(er), 64'd0);
    end

    tv.push_back('{1'b1, 64'h40,   2'd3, 1'b0, 64'h1122334455667788, 0, 64'h0, 1'b0});
    tv.push_back('{1'b0, 64'h40,   2'd3, 1'b0, 64'h0, 5, 64'h1122334455667788, 1'b0});
    tv.push_back('{1'b0, 64'h47,   2'd0, 1'b0, 64'h0, 0, 64'h0000000000000011, 1'b0});
    tv.push_back('{1'b1, 64'h47,   2'd0, 1'b0, 64'hFFFFFFFFFFFFFF80, 0, 64'h0, 1'b0});
    tv.push_back('{1'b0, 64'h47,   2'd0, 1'b0, 64'h0, 0, 64'hFFFFFFFFFFFFFF80, 1'b0});
    tv.push_back('{1'b0, 64'h47,   2'd0, 1'b1, 64'h0, 0, 64'h0000000000000080, 1'b0});
    tv.push_back('{1'b0, 64'h46,   2'd1, 1'b0, 64'h0, 0, 64'hFFFFFFFFFFFF8022, 1'b0});
    tv.push_back('{1'b0, 64'h44,   2'd2, 1'b0, 64'h0, 0, 64'hFFFFFFFF80223344, 1'b0});
    tv.push_back('{1'b0, 64'h44,   2'd2, 1'b1, 64'h0, 0, 64'h0000000080223344, 1'b0});
    tv.push_back('{1'b0, 64'h1000, 2'd3, 1'b0, 64'h0, 0, 64'h0, 1'b1});
    tv.push_back('{1'b1, 64'h1004, 2'd2, 1'b0, 64'h12345678, 0, 64'h0, 1'b1});
    tv.push_back('{1'b1, 64'h42,   2'd2, 1'b0, 64'h00000000CAFEBABE, 0, 64'h0, TRAP});
    tv.push_back('{1'b0, 64'h40,   2'd3, 1'b0, 64'h0, 0,
                   TRAP ? 64'h8022334455667788 : 64'h80223344CAFEBABE, 1'b0});
    tv.push_back('{1'b0, 64'h47,   2'd1, 1'b1, 64'h0, 0,
                   TRAP ? 64'h0 : 64'h0000000000008022, TRAP});
    tv.push_back('{1'b1, 64'hFFE,  2'd1, 1'b0, 64'h000000000000BEEF, 0, 64'h0, 1'b0});
    tv.push_back('{1'b0, 64'hFFE,  2'd1, 1'b1, 64'h0, 2, 64'h000000000000BEEF, 1'b0});
    tv.push_back('{1'b0, 64'hFFE,  2'd1, 1'b0, 64'h0, 0, 64'hFFFFFFFFFFFFBEEF, 1'b0});
    foreach (tv[i]) begin
      xact(tv[i].wr, tv[i].a, tv[i].sz, tv[i].u, tv[i].wd, tv[i].bp, rd, er, mrd, merr);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rd);
      chk($sformatf("vec%0d_error", i), 64'(er), 64'(tv[i].exp_err));
    end

    // Reset one cycle into WAIT discards the pending store
    xact(1'b0, 64'h40, 2'd3, 1'b0, 64'h0, 0, rd, er, mrd, merr);
    chk("pre_reset_load", rd, mrd);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h80; req_size = 2'd3;
    req_unsigned = 1'b0; req_wdata = 64'hDEAD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_wait_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_wait_rdata", rsp_rdata, 64'd0);
    chk("rst_wait_error", 64'(rsp_error), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_release_req_ready", 64'(req_ready), 64'd1);
    xact(1'b0, 64'h80, 2'd3, 1'b0, 64'h0, 0, rd, er, mrd, merr);
    chk("rst_discard_load", rd, mrd);
    chk("rst_discard_err", 64'(er), 64'd0);

    // Zero-latency instance, back-to-back with rsp_ready held high
    zv.push_back('{1'b1, 64'h0, 2'd3, 1'b0, 64'h0123456789ABCDEF, 64'h0});
    zv.push_back('{1'b0, 64'h0, 2'd3, 1'b0, 64'h0, 64'h0123456789ABCDEF});
    zv.push_back('{1'b0, 64'h7, 2'd0, 1'b0, 64'h0, 64'h0000000000000001});
    zv.push_back('{1'b0, 64'h6, 2'd1, 1'b0, 64'h0, 64'h0000000000000123});
    zv.push_back('{1'b0, 64'h0, 2'd0, 1'b1, 64'h0, 64'h00000000000000EF});
    zv.push_back('{1'b0, 64'h0, 2'd0, 1'b0, 64'h0, 64'hFFFFFFFFFFFFFFEF});
    z_req_valid = 1'b1;
    foreach (zv[i]) begin
      z_req_write = zv[i].wr; z_req_addr = zv[i].a; z_req_size = zv[i].sz;
      z_req_unsigned = zv[i].u; z_req_wdata = zv[i].wd;
      @(posedge clk); #1;
      chk($sformatf("lat0_%0d_rsp_valid", i), 64'(z_rsp_valid), 64'd1);
      chk($sformatf("lat0_%0d_rdata", i), z_rsp_rdata, zv[i].exp_rd);
      chk($sformatf("lat0_%0d_error", i), 64'(z_rsp_error), 64'd0);
      z_req_write = 1'b1; z_req_addr = 64'h0; z_req_wdata = {$urandom, $urandom};
      @(posedge clk); #1;
      chk($sformatf("lat0_%0d_idle", i), 64'({z_rsp_valid, z_req_ready}), 64'd1);
    end
    z_req_valid = 1'b0;

    // Randomized traffic against the reference model
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      a = 64'($urandom_range(0, 255));
      else if (r < 9) a = 64'(4088 + $urandom_range(0, 7));
      else if ($urandom_range(0, 1) == 0) a = 64'(4096 + $urandom_range(0, 100));
      else            a = {$urandom, $urandom} | 64'h8000000000000000;
      xact(1'($urandom), a, 2'($urandom), 1'($urandom), {$urandom, $urandom},
           $urandom_range(0, 2), rd, er, mrd, merr);
      chk($sformatf("rnd%0d_rdata", i), rd, mrd);
      chk($sformatf("rnd%0d_error", i), 64'(er), 64'(merr));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
